// File: rtl/id_ex_alu_stage_if.sv
// ID -> EX boundary bundle: decoded slot, stage control and forwarding inputs in,
// ALU operands and registered control out.
interface id_ex_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            stall;
    logic            flush;
    logic            in_valid;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic [REGW-1:0] in_rd;
    logic            in_alu_src;
    logic [1:0]      in_alu_op_class;
    logic [2:0]      in_funct3;
    logic            in_funct7b5;
    logic            in_reg_write;
    logic            in_mem_read;
    logic            in_mem_write;
    logic            in_mem_to_reg;
    logic            in_branch;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [XLEN-1:0] ex_mem_result;
    logic [XLEN-1:0] mem_wb_result;
    logic [XLEN-1:0] X;
    logic [XLEN-1:0] Y;
    logic [2:0]      ALUop;
    logic [XLEN-1:0] store_data;
    logic            ex_valid;
    logic            ex_illegal;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_mem_to_reg;
    logic            ex_branch;

    modport master (
        output stall, flush, in_valid, in_rs1_data, in_rs2_data, in_imm, in_rd,
               in_alu_src, in_alu_op_class, in_funct3, in_funct7b5,
               in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg, in_branch,
               fwd_a, fwd_b, ex_mem_result, mem_wb_result,
        input  X, Y, ALUop, store_data, ex_valid, ex_illegal, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch
    );

    modport slave (
        input  stall, flush, in_valid, in_rs1_data, in_rs2_data, in_imm, in_rd,
               in_alu_src, in_alu_op_class, in_funct3, in_funct7b5,
               in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg, in_branch,
               fwd_a, fwd_b, ex_mem_result, mem_wb_result,
        output X, Y, ALUop, store_data, ex_valid, ex_illegal, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch
    );
endinterface

// File: rtl/id_ex_alu_stage.sv
// ID/EX register with ALU-op decode and operand forwarding; 1 cycle ID -> X/Y/ALUop.
// No valid/ready: stall holds the whole slot, flush loads a bubble (flush beats stall).
module id_ex_alu_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic   clk,
    input  logic   reset,
    id_ex_if.slave bus
);
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic [2:0]      alu_op;
        logic            alu_src;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            branch;
    } stage_t;

    stage_t          stage_q, stage_d;
    logic [2:0]      dec_op;
    logic            dec_illegal;
    logic [XLEN-1:0] fwd_a_dat, fwd_b_dat, y_raw;

    always_comb begin
        dec_op      = OP_AND;
        dec_illegal = 1'b0;
        unique case (bus.in_alu_op_class)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            default: begin
                // R-type honours bit 30 on f3=000; I-type ADDI ignores it
                unique case (bus.in_funct3)
                    3'b000: dec_op = (bus.in_alu_op_class == 2'b10 && bus.in_funct7b5) ? OP_SUB : OP_ADD;
                    3'b111: dec_op = OP_AND;
                    3'b110: dec_op = OP_OR;
                    3'b101: begin
                        if (!bus.in_funct7b5) dec_op = OP_SRL;
                        else                  dec_illegal = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d = '0;
        end else if (!bus.stall) begin
            stage_d.valid      = bus.in_valid;
            stage_d.illegal    = dec_illegal;
            stage_d.alu_op     = dec_op;
            stage_d.alu_src    = bus.in_alu_src;
            stage_d.rd         = bus.in_rd;
            stage_d.rs1        = bus.in_rs1_data;
            stage_d.rs2        = bus.in_rs2_data;
            stage_d.imm        = bus.in_imm;
            // an unsupported encoding must not write architectural state
            stage_d.reg_write  = bus.in_reg_write & ~dec_illegal;
            stage_d.mem_read   = bus.in_mem_read;
            stage_d.mem_write  = bus.in_mem_write & ~dec_illegal;
            stage_d.mem_to_reg = bus.in_mem_to_reg;
            stage_d.branch     = bus.in_branch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) stage_q <= '0;
        else       stage_q <= stage_d;
    end

    always_comb begin
        unique case (bus.fwd_a)
            2'b01:   fwd_a_dat = bus.mem_wb_result;
            2'b10:   fwd_a_dat = bus.ex_mem_result;
            default: fwd_a_dat = stage_q.rs1;
        endcase
        unique case (bus.fwd_b)
            2'b01:   fwd_b_dat = bus.mem_wb_result;
            2'b10:   fwd_b_dat = bus.ex_mem_result;
            default: fwd_b_dat = stage_q.rs2;
        endcase
        y_raw = stage_q.alu_src ? stage_q.imm : fwd_b_dat;
    end

    assign bus.X          = fwd_a_dat;
    assign bus.Y          = (stage_q.alu_op == OP_SRL) ? {{(XLEN-5){1'b0}}, y_raw[4:0]} : y_raw;
    assign bus.ALUop      = stage_q.alu_op;
    assign bus.store_data = fwd_b_dat;
    assign bus.ex_valid      = stage_q.valid;
    assign bus.ex_illegal    = stage_q.illegal;
    assign bus.ex_rd         = stage_q.rd;
    assign bus.ex_reg_write  = stage_q.reg_write;
    assign bus.ex_mem_read   = stage_q.mem_read;
    assign bus.ex_mem_write  = stage_q.mem_write;
    assign bus.ex_mem_to_reg = stage_q.mem_to_reg;
    assign bus.ex_branch     = stage_q.branch;
endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Directed + random checks of id_ex_alu_stage against a slot-level reference model.
module tb_id_ex_alu_stage;
    localparam int ADD = 2, SUB = 3, AND_ = 0, OR_ = 1, SRL = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    id_ex_if #(.XLEN(32), .REGW(5)) bus ();

    id_ex_alu_stage #(.XLEN(32), .REGW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v, ill, src, rw, mr, mw, m2r, br;
        bit [31:0] rs1, rs2, imm;
        bit [4:0]  rd;
        int        op;
    } slot_t;

    slot_t m;

    // Returns the ALU op for a class/funct3/bit30 triple, or -1 if unsupported.
    function automatic int model_op(bit [1:0] cls, bit [2:0] f3, bit b5);
        if (cls == 0) return ADD;
        if (cls == 1) return SUB;
        if (f3 == 0) return (cls == 2 && b5) ? SUB : ADD;
        if (f3 == 7) return AND_;
        if (f3 == 6) return OR_;
        if (f3 == 5 && !b5) return SRL;
        return -1;
    endfunction

    function automatic bit [31:0] fwd_sel(bit [1:0] f, bit [31:0] reg_val);
        if (f == 1) return bus.mem_wb_result;
        if (f == 2) return bus.ex_mem_result;
        return reg_val;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        slot_t n;
        int    op;
        n = m;
        if (reset || bus.flush) begin
            n = '{default: 0};
        end else if (!bus.stall) begin
            op    = model_op(bus.in_alu_op_class, bus.in_funct3, bus.in_funct7b5);
            n.v   = bus.in_valid;
            n.rs1 = bus.in_rs1_data;
            n.rs2 = bus.in_rs2_data;
            n.imm = bus.in_imm;
            n.rd  = bus.in_rd;
            n.src = bus.in_alu_src;
            n.mr  = bus.in_mem_read;
            n.m2r = bus.in_mem_to_reg;
            n.br  = bus.in_branch;
            n.ill = (op < 0);
            n.op  = (op < 0) ? 0 : op;
            n.rw  = (op < 0) ? 1'b0 : bus.in_reg_write;
            n.mw  = (op < 0) ? 1'b0 : bus.in_mem_write;
        end
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic check_all(string tag);
        bit [31:0] xa, xb, yv;
        xa = fwd_sel(bus.fwd_a, m.rs1);
        xb = fwd_sel(bus.fwd_b, m.rs2);
        yv = m.src ? m.imm : xb;
        if (m.op == SRL) yv = yv % 32;
        check({tag, ".X"}, bus.X, xa);
        check({tag, ".Y"}, bus.Y, yv);
        check({tag, ".ALUop"}, {29'd0, bus.ALUop}, m.op[31:0]);
        check({tag, ".store"}, bus.store_data, xb);
        check({tag, ".ctl"},
              {20'd0, bus.ex_valid, bus.ex_illegal, bus.ex_rd, bus.ex_reg_write,
               bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_branch},
              {20'd0, m.v, m.ill, m.rd, m.rw, m.mr, m.mw, m.m2r, m.br});
    endtask

    task automatic drive(bit [1:0] cls, bit [2:0] f3, bit b5, bit [31:0] rs1,
                         bit [31:0] rs2, bit [31:0] imm, bit src, bit rw, bit mw);
        bus.in_valid        = 1'b1;
        bus.in_alu_op_class = cls;
        bus.in_funct3       = f3;
        bus.in_funct7b5     = b5;
        bus.in_rs1_data     = rs1;
        bus.in_rs2_data     = rs2;
        bus.in_imm          = imm;
        bus.in_alu_src      = src;
        bus.in_reg_write    = rw;
        bus.in_mem_write    = mw;
        bus.in_mem_read     = 1'b0;
        bus.in_mem_to_reg   = 1'b0;
        bus.in_branch       = 1'b0;
        bus.in_rd           = 5'd7;
    endtask

    initial begin
        m = '{default: 0};
        reset = 1'b1;
        bus.stall = 0; bus.flush = 0;
        bus.fwd_a = 0; bus.fwd_b = 0;
        bus.ex_mem_result = 0; bus.mem_wb_result = 0;
        drive(2'b10, 3'b111, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        bus.in_rd    = 5'd0;
        tick(); tick();
        check_all("reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_all("idle");
        check("idle.ALUop0", {29'd0, bus.ALUop}, 32'd0);

        drive(2'b10, 3'b000, 1'b1, 32'h10, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("sub");
        check("sub.ALUop", {29'd0, bus.ALUop}, 32'd3);
        check("sub.X", bus.X, 32'h10);
        check("sub.Y", bus.Y, 32'h3);
        check("sub.rw", {31'd0, bus.ex_reg_write}, 32'd1);

        reset = 1'b1;
        tick();
        check("rst_sub.valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_sub.ALUop", {29'd0, bus.ALUop}, 32'd0);
        reset = 1'b0;

        drive(2'b11, 3'b101, 1'b0, 32'h8000_0000, 32'h0, 32'h0000_0FE4, 1'b1, 1'b1, 1'b0);
        tick();
        check_all("srli");
        check("srli.Y", bus.Y, 32'h4);
        check("srli.ALUop", {29'd0, bus.ALUop}, 32'd4);
        drive(2'b10, 3'b101, 1'b0, 32'hF000_0000, 32'hFFFF_FF21, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("srl");
        check("srl.Y", bus.Y, 32'h1);

        drive(2'b10, 3'b000, 1'b0, 32'h1234, 32'h77, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        bus.fwd_a = 2'b10; bus.ex_mem_result = 32'hAAAA_0000;
        bus.fwd_b = 2'b01; bus.mem_wb_result = 32'h55;
        #1;
        check_all("fwd");
        check("fwd.X", bus.X, 32'hAAAA_0000);
        check("fwd.Y", bus.Y, 32'h55);
        check("fwd.store", bus.store_data, 32'h55);
        bus.fwd_a = 2'b11;
        #1;
        check("fwd11.X", bus.X, 32'h1234);
        bus.fwd_a = 0; bus.fwd_b = 0;

        bus.stall = 1'b1;
        drive(2'b00, 3'b010, 1'b0, 32'hDEAD, 32'hBEEF, 32'h44, 1'b1, 1'b0, 1'b1);
        tick();
        drive(2'b01, 3'b000, 1'b0, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("stall");
        check("stall.X", bus.X, 32'h1234);
        bus.flush = 1'b1;
        drive(2'b00, 3'b010, 1'b0, 32'hDEAD, 32'hBEEF, 32'h44, 1'b1, 1'b0, 1'b1);
        tick();
        check("stflush.valid", {31'd0, bus.ex_valid}, 32'd0);
        check("stflush.mw", {31'd0, bus.ex_mem_write}, 32'd0);
        bus.stall = 1'b0; bus.flush = 1'b0;

        drive(2'b10, 3'b010, 1'b0, 32'h5, 32'h6, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        check_all("illegal");
        check("illegal.ill", {31'd0, bus.ex_illegal}, 32'd1);
        check("illegal.rw", {31'd0, bus.ex_reg_write}, 32'd0);
        check("illegal.valid", {31'd0, bus.ex_valid}, 32'd1);
        drive(2'b00, 3'b010, 1'b0, 32'h100, 32'h99, 32'h40, 1'b1, 1'b0, 1'b1);
        tick();
        check_all("store");
        check("store.ALUop", {29'd0, bus.ALUop}, 32'd2);
        check("store.Y", bus.Y, 32'h40);
        check("store.mw", {31'd0, bus.ex_mem_write}, 32'd1);

        for (int i = 0; i < 300; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.in_valid        = $urandom_range(0, 1);
            bus.in_alu_op_class = 2'($urandom_range(0, 3));
            bus.in_funct3       = 3'($urandom_range(0, 7));
            bus.in_funct7b5     = $urandom_range(0, 1);
            bus.in_rs1_data     = $urandom;
            bus.in_rs2_data     = $urandom;
            bus.in_imm          = $urandom;
            bus.in_rd           = 5'($urandom_range(0, 31));
            bus.in_alu_src      = $urandom_range(0, 1);
            bus.in_reg_write    = $urandom_range(0, 1);
            bus.in_mem_read     = $urandom_range(0, 1);
            bus.in_mem_write    = $urandom_range(0, 1);
            bus.in_mem_to_reg   = $urandom_range(0, 1);
            bus.in_branch       = $urandom_range(0, 1);
            tick();
            bus.fwd_a = 2'($urandom_range(0, 3));
            bus.fwd_b = 2'($urandom_range(0, 3));
            bus.ex_mem_result = $urandom;
            bus.mem_wb_result = $urandom;
            #1;
            check_all("rand");
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_alu_stage.md
Name: id_ex_alu_stage

Overview:
ID/EX pipeline register and operand/ALU-control stage that sits directly upstream of the ALU in the RISC-V datapath. It captures decoded instruction fields and control at each clock edge, with stall and flush. It derives the 3-bit ALU operation code and drives the ALU X/Y operands through a forwarding mux and an immediate-select mux. Registered control bits pass through to the EX/MEM stage.

Parameters:
XLEN, 32, datapath width
REGW, 5, register index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous reset, active-high
stall  in  1  hold all stage registers
flush  in  1  load a bubble on next edge
in_valid  in  1  ID slot holds a real instruction
in_rs1_data  in  XLEN  register-file read A
in_rs2_data  in  XLEN  register-file read B
in_imm  in  XLEN  sign-extended immediate
in_rd  in  REGW  destination index
in_alu_src  in  1  1 = Y takes immediate
in_alu_op_class  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
in_funct3  in  3  instruction funct3
in_funct7b5  in  1  instruction bit 30
in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg, in_branch  in  1 each  main-control bits
fwd_a, fwd_b  in  2 each  00 reg, 01 MEM/WB, 10 EX/MEM, 11 reg
ex_mem_result  in  XLEN  forwarded EX/MEM value
mem_wb_result  in  XLEN  forwarded MEM/WB value
X  out  XLEN  ALU operand X
Y  out  XLEN  ALU operand Y
ALUop  out  3  ALU operation code
store_data  out  XLEN  forwarded rs2 for stores
ex_valid, ex_illegal  out  1 each  slot valid / unsupported encoding
ex_rd  out  REGW  registered rd
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control

Behaviour:
- Edge priority, highest first: reset > flush > stall > load.
- Reset and flush clear every register to 0: valid, all control, rd, rs1/rs2/imm, illegal. A flush during stall still bubbles.
- Stall holds every register unchanged. Forwarding muxes still follow the live fwd_* and result inputs.
- Load captures all in_* on the edge. Latency is 1 cycle from ID inputs to X/Y/ALUop.
- ALUop is decoded at input and registered (AND 000, OR 001, ADD 010, SUB 011, SRL 100):
  - class 00 -> ADD.
  - class 01 -> SUB.
  - class 10: f3 000 b5=0 ADD, 000 b5=1 SUB, 111 AND, 110 OR, 101 b5=0 SRL.
  - class 11: f3 000 ADD (b5 ignored), 111 AND, 110 OR, 101 b5=0 SRL.
  - Any other class 10/11 encoding -> ALUop 000, illegal=1, and reg_write/mem_write forced to 0 in the captured slot (valid kept).
  - A bubble decodes as ALUop 000 with illegal=0.
- Forward A (combinational, from registered rs1):
  - fwd_a=00 or 11 -> rs1_q.
  - fwd_a=01 -> mem_wb_result.
  - fwd_a=10 -> ex_mem_result.
- Forward B uses the same selection on fwd_b with rs2_q.
- X = forward A. store_data = forward B.
- Y = alu_src_q ? imm_q : forward B.
- Shift masking: when ALUop=SRL, Y[XLEN-1:5] = 0, so only the low 5 bits of the shift amount reach the ALU. This applies to the immediate as well.
- Reset values of outputs: X=0, Y=0, ALUop=000, store_data=0, every ex_* = 0. These hold until the first load.
- Forwarding inputs are not registered. The hazard unit must hold fwd_* stable across a stall.

Test Plan:
- Reset, then idle 3 cycles -> all outputs 0, ALUop=000. Assert reset while a SUB is held: next edge gives ex_valid=0, ALUop=000.
- Load R-type, f3=000, b5=1, rs1=0x10, rs2=0x3, fwd 00/00 -> next cycle ALUop=011, X=0x10, Y=0x3, ex_reg_write=1.
- I-type SRLI, imm=0x0000_0FE4, alu_src=1 -> ALUop=100, Y=0x4. Also R-type SRL with rs2=0xFFFF_FF21 -> Y=0x1.
- Loaded slot with fwd_a=10, ex_mem_result=0xAAAA_0000, fwd_b=01, mem_wb_result=0x55, alu_src=0 -> X=0xAAAA_0000, Y=0x55, store_data=0x55. fwd_a=11 -> X=rs1_q.
- Stall 2 cycles while in_* change -> registered outputs frozen. Stall+flush same cycle -> bubble (ex_valid=0, ex_mem_write=0).
- Class 10, f3=010 -> ex_illegal=1, ALUop=000, ex_reg_write=0, ex_valid=1. Class 00 store -> ALUop=010, ex_mem_write=1, Y=imm.
